// File: rtl/tdc_capture_ctrl.sv
// tdc_capture_ctrl
//   Sequences measurement runs on a carry-chain TDC tap vector. After an
//   accepted arm it registers the thermometer code every clock, encodes the
//   first transition position, suppresses repeat snapshots of the same edge
//   and accumulates count/min/max/sum over nsamp hits or until timeout. One
//   result record is then offered on a valid/ready handshake.
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   taps         sampled chain, taps[0] = chain entry
//   arm, nsamp   start request (IDLE only, nsamp != 0) and hits per run
//   busy         high while ARMED or DONE
//   res_valid/res_ready  result handshake
//   res_pos/min/max/sum/count/timeout  result record
module tdc_capture_ctrl #(
  parameter int WIDTH   = 100,
  parameter int POS_W   = 7,
  parameter int EDGE    = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH:0]     taps,
  input  logic               arm,
  input  logic [7:0]         nsamp,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [POS_W-1:0]   res_pos,
  output logic [POS_W-1:0]   res_min,
  output logic [POS_W-1:0]   res_max,
  output logic [POS_W+7:0]   res_sum,
  output logic [7:0]         res_count,
  output logic               res_timeout
);

  localparam int   TW  = $clog2(TIMEOUT + 1);
  localparam logic POL = (EDGE != 0);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   s1;
  logic             s1_vld;
  logic             s2_hit;
  logic [POS_W-1:0] s2_pos;
  logic             quiet;
  logic [7:0]       nsamp_q;
  logic [TW-1:0]    timer;

  logic             enc_trans;
  logic [POS_W-1:0] enc_pos;
  logic             hit_now;

  // Lowest tap differing from the chain entry; later bubbles are ignored.
  always_comb begin
    enc_trans = 1'b0;
    enc_pos   = '0;
    for (int unsigned i = 1; i <= WIDTH; i++) begin
      if (!enc_trans && (s1[i] != s1[0])) begin
        enc_trans = 1'b1;
        enc_pos   = POS_W'(i);
      end
    end
  end

  assign hit_now = s1_vld && enc_trans && (s1[0] == POL) && quiet;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      s1          <= '0;
      s1_vld      <= 1'b0;
      s2_hit      <= 1'b0;
      s2_pos      <= '0;
      quiet       <= 1'b1;
      nsamp_q     <= '0;
      timer       <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_pos     <= '0;
      res_min     <= '0;
      res_max     <= '0;
      res_sum     <= '0;
      res_count   <= '0;
      res_timeout <= 1'b0;
    end else begin
      // Snapshots captured outside ARMED (including the arm cycle) never qualify.
      s1     <= taps;
      s1_vld <= (state == ARMED);
      s2_hit <= hit_now;
      s2_pos <= enc_pos;

      if (s1_vld) begin
        if (hit_now)
          quiet <= 1'b0;
        else if (!enc_trans || (s1[0] != POL))
          quiet <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (arm && (nsamp != 8'd0)) begin
            state       <= ARMED;
            busy        <= 1'b1;
            quiet       <= 1'b1;
            nsamp_q     <= nsamp;
            timer       <= '0;
            res_pos     <= '0;
            res_min     <= '1;
            res_max     <= '0;
            res_sum     <= '0;
            res_count   <= '0;
            res_timeout <= 1'b0;
          end
        end
        ARMED: begin
          timer <= timer + 1'b1;
          if (s2_hit) begin
            res_pos   <= s2_pos;
            res_count <= res_count + 8'd1;
            res_sum   <= res_sum + (POS_W+8)'(s2_pos);
            if (s2_pos < res_min) res_min <= s2_pos;
            if (s2_pos > res_max) res_max <= s2_pos;
          end
          // Count completion wins over a timeout in the same cycle.
          if (s2_hit && (res_count + 8'd1 == nsamp_q)) begin
            state     <= DONE;
            res_valid <= 1'b1;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state       <= DONE;
            res_valid   <= 1'b1;
            res_timeout <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
module tb_tdc_capture_ctrl;
  localparam int W  = 100;
  localparam int PW = 7;
  localparam int TO = 50;

  typedef logic [W:0] tap_t;
  typedef struct {
    int pos, mn, mx, sum, cnt, tmo;
    longint vcyc;
  } rec_t;

  logic          clk = 0, reset = 1, arm = 0, res_ready = 0;
  tap_t          taps = '0;
  logic [7:0]    nsamp = 0;
  logic          busy, res_valid, res_timeout;
  logic [PW-1:0] res_pos, res_min, res_max;
  logic [PW+7:0] res_sum;
  logic [7:0]    res_count;

  tdc_capture_ctrl #(.WIDTH(W), .POS_W(PW), .EDGE(1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .taps(taps), .arm(arm), .nsamp(nsamp),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_pos(res_pos), .res_min(res_min), .res_max(res_max),
    .res_sum(res_sum), .res_count(res_count), .res_timeout(res_timeout));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  rec_t sb[$];
  tap_t plan[$];
  bit stall_next = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic tap_t rise(input int p);
    tap_t v = '0;
    for (int i = 0; i < p; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic tap_t rnd_snap();
    tap_t v;
    int   t = $urandom_range(0, 7);
    case (t)
      0: v = '0;
      1: v = '1;
      2, 3, 4: v = rise($urandom_range(1, W));
      5: v = ~rise($urandom_range(1, W));
      6: begin
        v = rise($urandom_range(3, W));
        v[$urandom_range(1, 2)] = 1'b0;
      end
      default: for (int i = 0; i <= W; i++) v[i] = 1'($urandom);
    endcase
    return v;
  endfunction

  // Reference: snapshot k (k>=1 after the arm cycle) reaches the accumulator
  // k+2 cycles after arm; the timeout closes the run at cycle TO.
  function automatic rec_t model(input int ns);
    rec_t r;
    bit quiet = 1, done = 0;
    r.pos = 0; r.mn = (1 << PW) - 1; r.mx = 0; r.sum = 0; r.cnt = 0;
    r.tmo = 1; r.vcyc = TO;
    for (int k = 1; k <= plan.size(); k++) begin
      tap_t v = plan[k-1];
      int p = 0;
      for (int i = W; i >= 1; i--) if (v[i] != v[0]) p = i;
      if (p != 0 && v[0] == 1'b1 && quiet) begin
        quiet = 0;
        if (!done && k + 2 <= TO) begin
          r.pos = p; r.cnt++; r.sum += p;
          if (p < r.mn) r.mn = p;
          if (p > r.mx) r.mx = p;
          if (r.cnt == ns) begin done = 1; r.tmo = 0; r.vcyc = k + 2; end
        end
      end else if (p == 0 || v[0] != 1'b1) quiet = 1;
    end
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      arm = busy ? 1'($urandom) : 1'b0;
      nsamp = 8'($urandom);
      taps = rnd_snap();
      n++;
    end
    arm = 0;
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run(input int ns);
    rec_t r;
    while (plan.size() < TO) plan.push_back(rnd_snap());
    r = model(ns);
    @(negedge clk);
    arm = 1; nsamp = 8'(ns); taps = rnd_snap();
    r.vcyc += cyc + 1;
    sb.push_back(r);
    foreach (plan[k]) begin
      @(negedge clk);
      arm = busy ? 1'($urandom) : 1'b0;
      nsamp = 8'($urandom);
      taps = plan[k];
    end
    plan.delete();
    wait_idle();
  endtask

  // Monitor: drives res_ready, pops on first sight of a record, then checks
  // the record stays stable until the handshake.
  initial begin
    bit have = 0;
    int hold = 0;
    rec_t e;
    forever begin
      @(negedge clk);
      if (reset) begin have = 0; res_ready = 0; continue; end
      if (hold > 0) begin res_ready = 0; hold--; end
      else res_ready = ($urandom_range(0, 2) != 0);
      if (res_valid) begin
        chk("busy_in_done", busy, 1);
        if (!have) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
            e = '{0, 0, 0, 0, 0, 0, cyc};
          end else begin
            e = sb.pop_front();
            chk("latency", cyc, e.vcyc);
          end
          have = 1;
          if (stall_next) begin stall_next = 0; hold = 10; res_ready = 0; end
        end
        chk("pos", res_pos, e.pos);
        chk("min", res_min, e.mn);
        chk("max", res_max, e.mx);
        chk("sum", res_sum, e.sum);
        chk("count", res_count, e.cnt);
        chk("timeout", res_timeout, e.tmo);
        if (res_ready) have = 0;
      end
    end
  end

  initial begin
    tap_t v;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_outputs", {res_pos, res_min, res_max, res_sum, res_count, res_timeout}, 0);

    // arm with nsamp=0 is ignored
    arm = 1; nsamp = 0;
    @(negedge clk);
    arm = 0;
    @(negedge clk);
    chk("nsamp0_busy", busy, 0);

    // single hit at 37
    plan.push_back(rise(37));
    run(1);
    // repeat snapshot suppression
    plan.push_back(rise(80)); plan.push_back(rise(95));
    plan.push_back('0); plan.push_back(rise(20));
    run(2);
    // bubble beyond the first difference
    v = rise(41); v[10] = 1'b0;
    plan.push_back(v);
    run(1);
    // wrong polarity then a rising hit
    plan.push_back(~rise(30)); plan.push_back(rise(30));
    run(1);
    // timeout with two hits, consumer stalled 10 cycles
    stall_next = 1;
    plan.push_back(rise(10)); plan.push_back('0); plan.push_back(rise(20));
    for (int i = 0; i < TO; i++) plan.push_back('0);
    run(3);
    // timeout with zero hits
    for (int i = 0; i < TO; i++) plan.push_back('1);
    run(4);

    for (int n = 0; n < 30; n++) run($urandom_range(1, 6));

    // reset mid-run: no record may appear
    @(negedge clk);
    arm = 1; nsamp = 8'd5; taps = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      arm = 0; taps = rise(10 * k);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", res_valid, 0);
    repeat (TO + 10) @(negedge clk);
    chk("midrst_still_idle", busy, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
